// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: MSB-first nibble-serial magnitude compare through a shared external 4-bit comparator
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   start, opa, opb     : request and operands, captured on the accepting edge in IDLE
//   busy, done          : busy while slices are being examined, done pulses one cycle at the end
//   gre, les, eq, err   : one-hot registered result, held until the next accepted start
//   cmp_x, cmp_y        : slice pair driven to the comparator (zero outside RUN)
//   cmp_gre/les/eq      : combinational comparator response for the current slice pair
module cmp_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             gre,
    output logic             les,
    output logic             eq,
    output logic             err,
    output logic [3:0]       cmp_x,
    output logic [3:0]       cmp_y,
    input  logic             cmp_gre,
    input  logic             cmp_les,
    input  logic             cmp_eq
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b;
    logic [IW-1:0]    r_idx;
    logic             r_busy, r_done, r_gre, r_les, r_eq, r_err;
    logic [2:0]       w_code;
    logic [IW+1:0]    w_lsb;
    logic             w_run;

    assign w_code = {cmp_gre, cmp_les, cmp_eq};
    assign w_lsb  = {r_idx, 2'b00};
    assign w_run  = r_state == RUN;
    assign cmp_x  = w_run ? r_a[w_lsb +: 4] : 4'd0;
    assign cmp_y  = w_run ? r_b[w_lsb +: 4] : 4'd0;

    assign busy = r_busy;
    assign done = r_done;
    assign gre  = r_gre;
    assign les  = r_les;
    assign eq   = r_eq;
    assign err  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gre   <= 1'b0;
            r_les   <= 1'b0;
            r_eq    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= opa;
                        r_b     <= opb;
                        r_idx   <= IW'(NSLICE - 1);
                        r_gre   <= 1'b0;
                        r_les   <= 1'b0;
                        r_eq    <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // an equal slice above the LSB slice is the only way to stay in RUN
                    if (w_code == 3'b001 && r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end else begin
                        r_gre   <= w_code == 3'b100;
                        r_les   <= w_code == 3'b010;
                        r_eq    <= w_code == 3'b001;
                        r_err   <= w_code != 3'b100 && w_code != 3'b010 && w_code != 3'b001;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: directed bench for cmp_seq_ctrl with a behavioural 4-bit comparator
module tb_cmp_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] opa = '0, opb = '0;
    logic        busy, done, gre, les, eq, err;
    logic [3:0]  cmp_x, cmp_y;
    logic        cmp_gre, cmp_les, cmp_eq;
    logic        fault = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign cmp_gre = fault ? 1'b1 : cmp_x > cmp_y;
    assign cmp_les = fault ? 1'b0 : cmp_x < cmp_y;
    assign cmp_eq  = fault ? 1'b1 : cmp_x == cmp_y;

    cmp_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .gre(gre), .les(les), .eq(eq), .err(err),
        .cmp_x(cmp_x), .cmp_y(cmp_y),
        .cmp_gre(cmp_gre), .cmp_les(cmp_les), .cmp_eq(cmp_eq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] res();
        return {gre, les, eq, err};
    endfunction

    // res codes: {gre,les,eq,err}
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int k, input logic [3:0] r);
        logic [15:0] sa, sb;
        @(negedge clk);
        opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            sa = a >> (4 * (3 - i));
            sb = b >> (4 * (3 - i));
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_cmp_x", cmp_x, sa[3:0]);
            check("run_cmp_y", cmp_y, sb[3:0]);
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_res", res(), r);
        check("done_cmp_x", cmp_x, 0);
        @(negedge clk);
        check("post_done", done, 0);
        check("post_res", res(), r);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", res(), 0);
        check("rst_cmp", {cmp_x, cmp_y}, 0);
        @(negedge clk);
        rst = 1'b0;

        op(16'h1234, 16'h1234, 4, 4'b0010);
        op(16'h8000, 16'h7FFF, 1, 4'b1000);
        op(16'h12A4, 16'h12B4, 3, 4'b0100);
        op(16'h0000, 16'h0000, 4, 4'b0010);
        op(16'hFFFE, 16'hFFFF, 4, 4'b0100);

        // restart and operand change during RUN must not disturb the running compare
        fork
            op(16'h1234, 16'h1234, 4, 4'b0010);
            begin
                repeat (3) @(negedge clk);
                start = 1'b1; opa = 16'hFFFF;
                @(negedge clk);
                start = 1'b0;
            end
        join

        // start held high: accepted every k+2 cycles, never during RUN/DONE
        @(negedge clk);
        opa = 16'h8000; opb = 16'h7FFF; start = 1'b1;
        @(negedge clk); check("hold_run", busy, 1);
        @(negedge clk); check("hold_done", done, 1); check("hold_done_busy", busy, 0);
        @(negedge clk); check("hold_idle", busy, 0); check("hold_idle_done", done, 0);
        @(negedge clk); check("hold_rerun", busy, 1); check("hold_res_clr", res(), 0);
        start = 1'b0;
        @(negedge clk); check("hold_done2", done, 1); check("hold_res2", res(), 4'b1000);
        @(negedge clk);

        // reset in the second RUN cycle abandons the compare
        opa = 16'h1234; opb = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_cmp_x", cmp_x, 2);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_res", res(), 0);
        check("arst_cmp", {cmp_x, cmp_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_done", {busy, done}, 0);
        end
        op(16'h4321, 16'h4320, 4, 4'b1000);

        fault = 1'b1;
        op(16'h5555, 16'h5555, 1, 4'b0001);
        fault = 1'b0;
        op(16'h0001, 16'h0002, 4, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
